// File: rtl/ifu_prefetch_pkg.sv
// Shared widths, reset address and PC step for the instruction-fetch slice.
package ifu_prefetch_pkg;

   localparam int unsigned DEF_CPU_WIDTH  = 32;
   localparam int unsigned DEF_INST_WIDTH = 32;
   localparam logic [31:0] DEF_RESET_PC   = 32'h8000_0000;
   localparam int unsigned PC_INC         = 4;

endpackage : ifu_prefetch_pkg

// File: rtl/ifu_prefetch_if.sv
// Fetch-unit bus bundle: redirect input, imem request/response port, decode port.
// The master modport is the fetch unit; the slave modport is its environment.
interface ifu_prefetch_if
   import ifu_prefetch_pkg::*;
#(
   parameter int unsigned CPU_WIDTH  = DEF_CPU_WIDTH,
   parameter int unsigned INST_WIDTH = DEF_INST_WIDTH
);

   logic                  redirect_valid;
   logic [CPU_WIDTH-1:0]  redirect_pc;
   logic                  imem_req_valid;
   logic                  imem_req_ready;
   logic [CPU_WIDTH-1:0]  imem_req_addr;
   logic                  imem_rsp_valid;
   logic [INST_WIDTH-1:0] imem_rsp_data;
   logic                  inst_valid;
   logic                  inst_ready;
   logic [INST_WIDTH-1:0] inst;
   logic [CPU_WIDTH-1:0]  inst_pc;

   modport master (
      input  redirect_valid, redirect_pc,
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid, imem_rsp_data,
      output inst_valid, inst, inst_pc,
      input  inst_ready
   );

   modport slave (
      output redirect_valid, redirect_pc,
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid, imem_rsp_data,
      input  inst_valid, inst, inst_pc,
      output inst_ready
   );

endinterface : ifu_prefetch_if

// File: rtl/ifu_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO with flush, wrap-around
// pointers and an occupancy output. Push when full / pop when empty are ignored.
module ifu_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_push_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_head,
   output logic                       o_valid,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign w_push_ok = i_push && (r_count != FULL);
   assign w_pop_ok  = i_pop && (r_count != {(AW+1){1'b0}});

   // Pointer and occupancy bookkeeping; flush empties the queue outright.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {(AW+1){1'b0}};
      end else if (i_flush) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {(AW+1){1'b0}};
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage write; contents are don't-care until counted as occupied.
   always_ff @(posedge clk) begin
      if (w_push_ok && !i_flush) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_valid = (r_count != {(AW+1){1'b0}});
   assign o_count = r_count;

endmodule : ifu_fifo

// File: rtl/ifu_prefetch.sv
// Decoupled instruction fetch: owns the fetch PC, issues in-order imem
// requests under a credit limit, queues returned words with their PC and
// discards responses that belong to requests made before a redirect.
module ifu_prefetch
   import ifu_prefetch_pkg::*;
#(
   parameter int unsigned          CPU_WIDTH  = DEF_CPU_WIDTH,
   parameter int unsigned          INST_WIDTH = DEF_INST_WIDTH,
   parameter int unsigned          DEPTH      = 4,
   parameter logic [CPU_WIDTH-1:0] RESET_PC   = CPU_WIDTH'(DEF_RESET_PC)
)(
   input  logic          clk,
   input  logic          rst_n,
   ifu_prefetch_if.master bus
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CPU_WIDTH-1:0] W_INC = CPU_WIDTH'(PC_INC);

   logic [CPU_WIDTH-1:0] r_fetch_pc;
   logic [CPU_WIDTH-1:0] r_rsp_pc;
   logic [CW-1:0]        r_out_cnt;
   logic [CW-1:0]        r_drop_cnt;

   logic [CW-1:0]        w_count;
   logic [CW-1:0]        w_live;
   logic [CW:0]          w_pending;
   logic [CW-1:0]        w_out_next;
   logic                 w_req_valid;
   logic                 w_req_fire;
   logic                 w_rsp_stale;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_redirect;
   logic                 w_head_valid;
   logic [CPU_WIDTH-1:0] w_redirect_pc;
   logic [INST_WIDTH+CPU_WIDTH-1:0] w_head;
   logic                 w_unused_pc_lo;

   // Credits: never more than DEPTH outstanding, and every live request must
   // have a queue slot reserved so a returning word can always be pushed.
   assign w_live      = r_out_cnt - r_drop_cnt;
   assign w_pending   = {1'b0, w_count} + {1'b0, w_live};
   assign w_req_valid = rst_n && (r_out_cnt < CW'(DEPTH)) && (w_pending < (CW+1)'(DEPTH));
   assign w_req_fire  = w_req_valid && bus.imem_req_ready;

   assign w_redirect     = bus.redirect_valid;
   assign w_redirect_pc  = {bus.redirect_pc[CPU_WIDTH-1:2], 2'b00};
   assign w_unused_pc_lo = ^bus.redirect_pc[1:0];

   // Redirect outranks everything: the arriving word and any pop are ignored.
   assign w_rsp_stale = (r_drop_cnt != {CW{1'b0}});
   assign w_push      = bus.imem_rsp_valid && !w_rsp_stale && !w_redirect;
   assign w_pop       = w_head_valid && bus.inst_ready && !w_redirect;
   assign w_out_next  = r_out_cnt + CW'(w_req_fire) - CW'(bus.imem_rsp_valid);

   // Fetch and response PCs; both restart at the aligned target on redirect.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fetch_pc <= RESET_PC;
         r_rsp_pc   <= RESET_PC;
      end else if (w_redirect) begin
         r_fetch_pc <= w_redirect_pc;
         r_rsp_pc   <= w_redirect_pc;
      end else begin
         r_fetch_pc <= w_req_fire ? (r_fetch_pc + W_INC) : r_fetch_pc;
         r_rsp_pc   <= w_push     ? (r_rsp_pc + W_INC)   : r_rsp_pc;
      end
   end

   // Outstanding and to-be-dropped counts; on redirect every request still
   // unanswered after this cycle, including one accepted now, becomes stale.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_cnt  <= {CW{1'b0}};
         r_drop_cnt <= {CW{1'b0}};
      end else begin
         r_out_cnt <= w_out_next;
         if (w_redirect) begin
            r_drop_cnt <= w_out_next;
         end else if (bus.imem_rsp_valid && w_rsp_stale) begin
            r_drop_cnt <= r_drop_cnt - CW'(1);
         end else begin
            r_drop_cnt <= r_drop_cnt;
         end
      end
   end

   ifu_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (INST_WIDTH + CPU_WIDTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_flush     (w_redirect),
      .i_push      (w_push),
      .i_push_data ({bus.imem_rsp_data, r_rsp_pc}),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_valid     (w_head_valid),
      .o_count     (w_count)
   );

   assign bus.imem_req_valid = w_req_valid;
   assign bus.imem_req_addr  = r_fetch_pc;
   assign bus.inst_valid     = w_head_valid;
   assign bus.inst           = w_head[INST_WIDTH+CPU_WIDTH-1:CPU_WIDTH];
   assign bus.inst_pc        = w_head[CPU_WIDTH-1:0];

endmodule : ifu_prefetch

// File: tb/tb_ifu_prefetch.sv
// Randomised bench for ifu_prefetch: an in-order memory with configurable
// latency, a queue-level reference model and a per-cycle output compare.
module tb_ifu_prefetch;
   import ifu_prefetch_pkg::*;

   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h8000_0000;

   typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
   typedef struct { logic [31:0] addr; bit stale; }       fl_t;
   typedef struct { logic [31:0] addr; int due; }         mr_t;

   logic clk;
   logic rst_n;

   ifu_prefetch_if #(.CPU_WIDTH(32), .INST_WIDTH(32)) ifc ();

   ifu_prefetch #(
      .CPU_WIDTH  (32),
      .INST_WIDTH (32),
      .DEPTH      (DEPTH),
      .RESET_PC   (RST_PC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   ent_t mq[$];        // expected decode queue
   fl_t  inflight[$];  // requests the model has issued, oldest first
   mr_t  memq[$];      // requests the memory has accepted

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          lat = 1;
   int          p_ready = 100;
   int          ir_mode = 0;
   int          n_fire = 0;
   bit          alt = 1'b0;
   bit          m_init = 1'b0;
   logic        s_req_valid;
   logic [31:0] s_req_addr;
   logic [31:0] m_fetch = RST_PC;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic int live_n();
      int n = 0;
      foreach (inflight[i]) if (!inflight[i].stale) n++;
      return n;
   endfunction

   function automatic bit exp_valid();
      return rst_n && (inflight.size() < DEPTH) && ((mq.size() + live_n()) < DEPTH);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle compare of every DUT output against the model.
   always @(negedge clk) begin
      s_req_valid = ifc.imem_req_valid;
      s_req_addr  = ifc.imem_req_addr;
      if (m_init) begin
         chk("req_valid", {31'd0, s_req_valid}, {31'd0, exp_valid()});
         if (exp_valid()) chk("req_addr", s_req_addr, m_fetch);
         chk("inst_valid", {31'd0, ifc.inst_valid}, {31'd0, (mq.size() != 0)});
         if (mq.size() != 0) begin
            chk("inst", ifc.inst, mq[0].data);
            chk("inst_pc", ifc.inst_pc, mq[0].pc);
         end
      end
   end

   // One clock cycle: drive inputs, then advance memory and model at the edge.
   task automatic step(input bit rst_v = 1'b1, input bit redir = 1'b0,
                       input logic [31:0] rpc = 32'h0);
      bit   ev;
      bit   dfire;
      bit   pop_now;
      fl_t  fl;
      rst_n              = rst_v;
      ifc.redirect_valid = redir;
      ifc.redirect_pc    = rpc;
      ifc.imem_req_ready = (int'($urandom_range(99)) < p_ready);
      case (ir_mode)
         0:       ifc.inst_ready = 1'b1;
         1:       ifc.inst_ready = 1'b0;
         2:       begin alt = !alt; ifc.inst_ready = alt; end
         default: ifc.inst_ready = 1'($urandom_range(1));
      endcase
      if (rst_v && memq.size() != 0 && memq[0].due <= cyc) begin
         ifc.imem_rsp_valid = 1'b1;
         ifc.imem_rsp_data  = memfn(memq[0].addr);
      end else begin
         ifc.imem_rsp_valid = 1'b0;
         ifc.imem_rsp_data  = $urandom;
      end
      @(posedge clk);
      if (!rst_v) begin
         mq.delete();
         inflight.delete();
         memq.delete();
         m_fetch = RST_PC;
         m_init  = 1'b1;
      end else if (m_init) begin
         ev      = exp_valid() && ifc.imem_req_ready;
         dfire   = s_req_valid && ifc.imem_req_ready;
         pop_now = (mq.size() != 0) && ifc.inst_ready;
         if (dfire) n_fire++;
         if (ifc.imem_rsp_valid) memq.delete(0);
         if (dfire) memq.push_back('{s_req_addr, cyc + lat});
         if (ifc.imem_rsp_valid) begin
            if (inflight.size() == 0) begin
               chk("rsp_has_request", 32'd0, 32'd1);
            end else begin
               fl = inflight[0];
               inflight.delete(0);
               if (!fl.stale && !redir) mq.push_back('{fl.addr, memfn(fl.addr)});
            end
         end
         if (ev) begin
            inflight.push_back('{m_fetch, 1'b0});
            m_fetch += 32'd4;
         end
         if (pop_now && !redir) mq.delete(0);
         if (redir) begin
            mq.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            m_fetch = {rpc[31:2], 2'b00};
         end
      end
      cyc++;
      #1;
   endtask

   initial begin
      rst_n              = 1'b0;
      ifc.redirect_valid = 1'b0;
      ifc.redirect_pc    = 32'h0;
      ifc.imem_req_ready = 1'b0;
      ifc.imem_rsp_valid = 1'b0;
      ifc.imem_rsp_data  = 32'h0;
      ifc.inst_ready     = 1'b0;

      // Reset release and back-to-back streaming with 1-cycle memory.
      lat = 1; p_ready = 100; ir_mode = 0;
      step(1'b0); step(1'b0);
      rst_n = 1'b1;
      #2;
      chk("rst_req_valid", {31'd0, ifc.imem_req_valid}, 32'd1);
      chk("rst_req_addr", ifc.imem_req_addr, 32'h8000_0000);
      chk("rst_inst_valid", {31'd0, ifc.inst_valid}, 32'd0);
      step(); step();
      #2;
      chk("seq_first_pc", ifc.inst_pc, 32'h8000_0000);
      chk("seq_req_addr", ifc.imem_req_addr, 32'h8000_0008);
      repeat (20) step();

      // Decode stalled: exactly DEPTH requests, then one more per pop.
      step(1'b0);
      n_fire = 0; ir_mode = 1;
      repeat (12) step();
      chk("stall_fires", 32'(n_fire), 32'd4);
      chk("stall_req_valid", {31'd0, ifc.imem_req_valid}, 32'd0);
      ir_mode = 0; step(); ir_mode = 1;
      repeat (8) step();
      chk("stall_refill_fires", 32'(n_fire), 32'd5);

      // Redirect with three requests in flight.
      ir_mode = 0; lat = 10;
      step(1'b0);
      repeat (3) step();
      p_ready = 0;
      step(1'b1, 1'b1, 32'h8000_0102);
      p_ready = 100;
      #1;
      chk("redir_inst_valid", {31'd0, ifc.inst_valid}, 32'd0);
      chk("redir_req_valid", {31'd0, ifc.imem_req_valid}, 32'd1);
      chk("redir_req_addr", ifc.imem_req_addr, 32'h8000_0100);
      for (int k = 0; k < 60 && !ifc.inst_valid; k++) step();
      chk("redir_live_seen", {31'd0, ifc.inst_valid}, 32'd1);
      chk("redir_first_pc", ifc.inst_pc, 32'h8000_0100);
      repeat (10) step();

      // Redirect coinciding with request, response and pop.
      lat = 1;
      step(1'b0);
      repeat (6) step();
      step(1'b1, 1'b1, 32'h8000_0200);
      #1;
      chk("same_inst_valid", {31'd0, ifc.inst_valid}, 32'd0);
      repeat (12) step();

      // PC wrap across the top of the address space.
      step(1'b1, 1'b1, 32'hFFFF_FFF9);
      repeat (12) step();

      // Reset mid-operation with responses pending.
      lat = 3;
      repeat (5) step();
      step(1'b0);
      rst_n = 1'b1;
      #1;
      chk("mid_rst_inst_valid", {31'd0, ifc.inst_valid}, 32'd0);
      chk("mid_rst_req_valid", {31'd0, ifc.imem_req_valid}, 32'd1);
      chk("mid_rst_req_addr", ifc.imem_req_addr, 32'h8000_0000);

      // Random traffic: latency, back-pressure, decode stalls, redirects.
      p_ready = 70;
      for (int i = 0; i < 900; i++) begin
         if (i % 100 == 0) ir_mode = (ir_mode == 2) ? 3 : 2;
         if ($urandom_range(199) == 0) begin
            lat = int'($urandom_range(4, 1));
            step(1'b0);
         end else if ($urandom_range(99) < 4) begin
            step(1'b1, 1'b1, 32'h8000_0000 | ($urandom & 32'h0000_0FFF));
         end else begin
            step();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_ifu_prefetch

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction-fetch unit that replaces the bare `inst` input / `curr_pc` output pair of the single-cycle core with a decoupled fetch path. It owns the fetch PC, issues in-order requests to instruction memory over a valid/ready port, and buffers returned words in a DEPTH-entry prefetch queue. It also flushes that queue and discards stale in-flight responses when the execute stage redirects on a branch or jump.

## Interface
- `CPU_WIDTH`, 32: address/PC width.
- `INST_WIDTH`, 32: instruction word width.
- `DEPTH`, 4: prefetch queue entries and maximum in-flight requests; power of two, ≥2.
- `RESET_PC`, 32'h8000_0000: first fetch address after reset.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `redirect_valid`  in  1  taken branch/jump; flush and refetch.
- `redirect_pc`  in  CPU_WIDTH  new fetch address; bits [1:0] ignored (treated as 0).
- `imem_req_valid`  out  1  fetch request.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  CPU_WIDTH  fetch address, word-aligned.
- `imem_rsp_valid`  in  1  response word valid; in order, never back-pressured.
- `imem_rsp_data`  in  INST_WIDTH  response word.
- `inst_valid`  out  1  queue head valid.
- `inst_ready`  in  1  decode consumes head.
- `inst`  out  INST_WIDTH  head instruction.
- `inst_pc`  out  CPU_WIDTH  PC of head instruction.

## Operation
- State:
  - `fetch_pc`: next address to request.
  - `rsp_pc`: PC of the next live response.
  - `out_cnt`: requests accepted but not yet answered.
  - `drop_cnt`: stale in-flight requests whose responses are to be discarded.
  - `count`: queue occupancy.
- `live = out_cnt - drop_cnt`.
- Issue condition: `imem_req_valid = (out_cnt < DEPTH) && (count + live < DEPTH)`. It is driven from registered state only; `imem_req_addr = fetch_pc`.
- Memory samples address only on handshake. Valid/addr stability before handshake is not required, and they may change after a redirect.
- Request handshake: `fetch_pc += 4` and `out_cnt++`.
- Response:
  - Every response decrements `out_cnt`.
  - If `drop_cnt > 0`, the response is discarded and `drop_cnt--`.
  - Otherwise the word is pushed with `rsp_pc`, and then `rsp_pc += 4`.
- Pop on `inst_valid && inst_ready`. `inst_valid = (count != 0)`.
- Redirect cycle; redirect has priority over all other events that cycle:
  - Queue is cleared (`count <= 0`); any pop that cycle is ignored.
  - A response arriving that cycle is discarded.
  - `fetch_pc <= rsp_pc <= {redirect_pc[CPU_WIDTH-1:2], 2'b00}`.
  - `drop_cnt <=` value of `out_cnt` after this cycle's request and response updates. A request handshaking in the redirect cycle is therefore stale.
- The credit rule guarantees a push never occurs when full. A simultaneous push and pop leaves `count` unchanged.
- Counters are `$clog2(DEPTH)+1` bits wide. PC additions wrap modulo 2^CPU_WIDTH.

## Timing
- Reset values (`rst_n` low at an edge):
  - `fetch_pc = rsp_pc = RESET_PC`.
  - `out_cnt = drop_cnt = count = 0`.
  - `imem_req_valid = 1` in the first cycle after release; 0 while `rst_n` is low.
  - `inst_valid = 0`.
  - `inst` and `inst_pc` are don't-care while `inst_valid = 0`.
- Reset mid-operation discards all state at the next edge. The instruction memory must be reset in the same cycle; no pre-reset responses may arrive afterward.
- Response to head: a word returned in cycle N is visible at `inst`/`inst_valid` in N+1. If the queue is not empty, it appears behind the existing entries.
- Redirect in cycle N:
  - `inst_valid = 0` in N+1.
  - The first request to `redirect_pc` is presented in N+1.
  - The first live instruction appears one cycle after its response, once `drop_cnt` has drained.
- Sustained throughput: one instruction per cycle when the memory returns one response per cycle and decode is always ready.

## Structure
- Shared defines/package:
  - `CPU_WIDTH`, `INST_WIDTH`, `RESET_PC`.
  - PC increment constant 4.
- One sub-module, `ifu_fifo`: DEPTH × (INST_WIDTH+CPU_WIDTH) synchronous FIFO with flush input, count output, wrap-around pointers.
- Counters and PC logic stay in `ifu_prefetch`.

## Test plan
- Reset release, memory always ready with 1-cycle latency, decode always ready -> requests 0x80000000, 0x80000004, … in consecutive cycles; `inst_pc` follows the same sequence one cycle after each response.
- `inst_ready = 0` held, DEPTH = 4 -> exactly 4 requests issued; `imem_req_valid` stays 0 until the first pop, then exactly one new request is issued.
- 3 requests in flight, `redirect_valid = 1` with `redirect_pc = 0x80000102` -> those 3 responses are dropped; `drop_cnt` returns to 0; the next request and first live `inst_pc` are 0x80000100.
- Redirect in the same cycle as a request handshake, a response, and a pop -> that response is not queued; `count = 0` next cycle; the handshaken request's response is dropped later.
- DEPTH = 2, alternating `inst_ready` with 3-cycle memory latency, ~200 cycles with random redirects -> `out_cnt` ≤ 2, no overflow, `inst_pc` always strictly sequential between redirects.
- `rst_n` low for one cycle with 2 responses pending (memory also reset) -> next cycle all counters are 0, `inst_valid = 0`, fetch restarts at RESET_PC.
